// File: rtl/and_gate_stim_pkg.sv
// rtl/and_gate_stim_pkg.sv - shared types and constants for the AND gate stimulus checker
package and_gate_stim_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } stim_state_t;

   localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
   localparam logic [7:0]  ERR_MAX      = 8'd255;

   // Galois tap mask for the operand width; anything other than 16 uses the 8-bit polynomial
   function automatic logic [15:0] select_taps(input int width);
      return (width == 16) ? LFSR_TAPS_16 : {8'h00, LFSR_TAPS_8};
   endfunction

endpackage

// File: rtl/and_gate_stimulus_checker_if.sv
// rtl/and_gate_stimulus_checker_if.sv - operand/result bus between the checker and the AND gate
interface and_gate_stimulus_checker_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] first_data_out;
   logic [DATA_WIDTH-1:0] second_data_out;
   logic                  data_valid_out;
   logic [DATA_WIDTH-1:0] result_in;

   // checker side: drives operands, receives the gate result
   modport master (
      output first_data_out,
      output second_data_out,
      output data_valid_out,
      input  result_in
   );

   // gate side: consumes operands, returns the result
   modport slave (
      input  first_data_out,
      input  second_data_out,
      input  data_valid_out,
      output result_in
   );

endinterface

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - right-shifting Galois LFSR with load-to-seed and step enable
module lfsr_galois #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 'hB8,
   parameter logic [WIDTH-1:0] SEED  = 'hD5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   output logic [WIDTH-1:0] state
);

   // load wins over enable so a restart always begins from the seed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED;
      end else if (load) begin
         state <= SEED;
      end else if (enable) begin
         state <= (state >> 1) ^ (state[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/and_gate_stimulus_checker.sv
// rtl/and_gate_stimulus_checker.sv - LFSR-driven exerciser and result checker for the registered AND gate
module and_gate_stimulus_checker
   import and_gate_stim_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    NUM_VECTORS    = 16,
   parameter int                    RESULT_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] SEED_A         = 'hD5,
   parameter logic [DATA_WIDTH-1:0] SEED_B         = 'hAA
) (
   input  logic                         system_clock,
   input  logic                         system_rst,
   input  logic                         start,
   input  logic                         hold,
   and_gate_stimulus_checker_if.master  dut_bus,
   output logic                         busy,
   output logic                         done,
   output logic [7:0]                   error_count,
   output logic                         pass
);

   localparam logic [DATA_WIDTH-1:0] TAPS     = DATA_WIDTH'(select_taps(DATA_WIDTH));
   localparam logic [15:0]           LAST_VEC = 16'(NUM_VECTORS - 1);
   localparam logic [15:0]           WAIT_END = 16'(RESULT_LATENCY);

   stim_state_t           state;
   logic [15:0]           vec_cnt;
   logic [15:0]           wait_cnt;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;

   logic [RESULT_LATENCY-1:0] pipe_valid;
   logic [DATA_WIDTH-1:0]     pipe_data [RESULT_LATENCY];

   logic       start_ok;
   logic       issue;
   logic       last_issue;
   logic       lfsr_step;
   logic       mismatch;
   logic [7:0] err_next;

   // issue/step decisions and the saturating error update shared by the FSM
   always_comb begin
      start_ok   = start && ((state == IDLE) || (state == DONE));
      issue      = (state == DRIVE) && valid_q && !hold;
      last_issue = issue && (vec_cnt == LAST_VEC);
      lfsr_step  = issue && !last_issue;
      mismatch   = pipe_valid[RESULT_LATENCY-1] &&
                   (dut_bus.result_in != pipe_data[RESULT_LATENCY-1]);
      err_next   = error_count;
      if (mismatch && (error_count != ERR_MAX)) begin
         err_next = error_count + 8'd1;
      end
   end

   lfsr_galois #(
      .WIDTH (DATA_WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED_A)
   ) u_lfsr_a (
      .clk    (system_clock),
      .rst    (system_rst),
      .load   (start_ok),
      .enable (lfsr_step),
      .state  (op_a)
   );

   lfsr_galois #(
      .WIDTH (DATA_WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED_B)
   ) u_lfsr_b (
      .clk    (system_clock),
      .rst    (system_rst),
      .load   (start_ok),
      .enable (lfsr_step),
      .state  (op_b)
   );

   assign dut_bus.first_data_out  = op_a;
   assign dut_bus.second_data_out = op_b;
   assign dut_bus.data_valid_out  = valid_q;

   // expected-result delay line: head captures what is on the bus this cycle, tail lines up with result_in
   always_ff @(posedge system_clock or posedge system_rst) begin
      if (system_rst) begin
         pipe_valid <= '0;
         for (int i = 0; i < RESULT_LATENCY; i++) begin
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= valid_q;
         pipe_data[0]  <= op_a & op_b;
         for (int i = 1; i < RESULT_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   // run sequencing: issue vectors, drain the pipeline, then report
   always_ff @(posedge system_clock or posedge system_rst) begin
      if (system_rst) begin
         state       <= IDLE;
         valid_q     <= 1'b0;
         vec_cnt     <= '0;
         wait_cnt    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error_count <= '0;
         pass        <= 1'b0;
      end else begin
         error_count <= err_next;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= DRIVE;
                  valid_q     <= 1'b1;
                  vec_cnt     <= '0;
                  wait_cnt    <= '0;
                  error_count <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
               end
            end
            DRIVE: begin
               if (hold) begin
                  valid_q <= 1'b0;
               end else if (!valid_q) begin
                  // coming out of a hold: re-present the pair that was never issued
                  valid_q <= 1'b1;
               end else begin
                  vec_cnt <= vec_cnt + 16'd1;
                  if (last_issue) begin
                     valid_q  <= 1'b0;
                     wait_cnt <= '0;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == WAIT_END) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 8'd0);
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
